// File: rtl/axi4_burst_mgr_if.sv
// axi4_bus_if: AXI4 bus bundle with the manager-side modport used by axi4_burst_mgr.
interface axi4_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 9
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [5:0]              aw_atop;
    logic                    aw_user;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_user;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic                    ar_user;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
    logic                    r_ready;

    modport manager (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi4_burst_mgr.sv
// axi4_burst_mgr: independent AXI4 INCR write/read burst FSMs fed from/to data FIFOs.
// Define AXI4_BURST_MGR_4K_CHECK_EN to reject bursts that cross a 4 KiB boundary.
module axi4_burst_mgr #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 9,
    parameter int WR_ID          = 0,
    parameter int RD_ID          = 0,
    parameter int MAX_BURST_LEN  = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      wr_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [7:0]                wr_len_i,
    input  logic                      rd_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [7:0]                rd_len_i,
    input  logic                      wr_fifo_gnt_i,
    input  logic [AXI_DATA_WIDTH-1:0] wr_fifo_data_i,
    output logic                      wr_fifo_req_o,
    input  logic                      rd_fifo_req_i,
    output logic                      rd_fifo_gnt_o,
    output logic [AXI_DATA_WIDTH-1:0] rd_fifo_data_o,
    output logic                      wr_done_o,
    output logic                      rd_done_o,
    output logic [1:0]                wr_err_o,
    output logic [1:0]                rd_err_o,
    output logic                      busy_o,
    axi4_bus_if.manager               axi_mgr_if
);
    localparam int         SIZE    = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [7:0] MAX_LEN = 8'(MAX_BURST_LEN - 1);

    typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;

    wr_state_e                 r_wr_state, w_wr_next;
    rd_state_e                 r_rd_state, w_rd_next;
    logic [AXI_ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr;
    logic [7:0]                r_wr_len, r_rd_len, r_wr_cnt;
    logic [8:0]                r_rd_cnt;
    logic [1:0]                r_wr_err, r_rd_err;
    logic                      r_wr_done, r_rd_done;
    logic [7:0]                w_wr_len, w_rd_len;
    logic                      w_wr_x, w_rd_x;
    logic                      w_aw_valid, w_w_valid, w_b_ready, w_ar_valid, w_r_ready;
    logic                      w_w_last, w_w_hs, w_r_hs;

    assign w_wr_len = (wr_len_i > MAX_LEN) ? MAX_LEN : wr_len_i;
    assign w_rd_len = (rd_len_i > MAX_LEN) ? MAX_LEN : rd_len_i;

`ifdef AXI4_BURST_MGR_4K_CHECK_EN
    // burst end offset within the 4 KiB page; past 4096 means it spills into the next page
    assign w_wr_x = (16'(wr_addr_i[11:0]) + ((16'(w_wr_len) + 16'd1) << SIZE)) > 16'd4096;
    assign w_rd_x = (16'(rd_addr_i[11:0]) + ((16'(w_rd_len) + 16'd1) << SIZE)) > 16'd4096;
`else
    assign w_wr_x = 1'b0;
    assign w_rd_x = 1'b0;
`endif

    assign w_w_last = (r_wr_cnt == r_wr_len);
    assign w_w_hs   = w_w_valid & axi_mgr_if.w_ready;
    assign w_r_hs   = axi_mgr_if.r_valid & w_r_ready;

    // handshake-facing outputs are gated by rstn_i so nothing toggles while reset is held
    always_comb begin
        w_wr_next  = r_wr_state;
        w_aw_valid = 1'b0;
        w_w_valid  = 1'b0;
        w_b_ready  = 1'b0;
        case (r_wr_state)
            WR_IDLE: if (wr_req_i && !w_wr_x) w_wr_next = WR_AW;
            WR_AW: begin
                w_aw_valid = rstn_i;
                if (axi_mgr_if.aw_ready) w_wr_next = WR_W;
            end
            WR_W: begin
                w_w_valid = rstn_i & wr_fifo_gnt_i;
                if (wr_fifo_gnt_i && axi_mgr_if.w_ready && w_w_last) w_wr_next = WR_B;
            end
            default: begin
                w_b_ready = rstn_i;
                if (axi_mgr_if.b_valid) w_wr_next = WR_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_next  = r_rd_state;
        w_ar_valid = 1'b0;
        w_r_ready  = 1'b0;
        case (r_rd_state)
            RD_IDLE: if (rd_req_i && !w_rd_x) w_rd_next = RD_AR;
            RD_AR: begin
                w_ar_valid = rstn_i;
                if (axi_mgr_if.ar_ready) w_rd_next = RD_R;
            end
            default: begin
                w_r_ready = rstn_i & rd_fifo_req_i;
                if (axi_mgr_if.r_valid && rd_fifo_req_i && axi_mgr_if.r_last) w_rd_next = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wr_state <= WR_IDLE;
            r_wr_addr  <= '0;
            r_wr_len   <= '0;
            r_wr_cnt   <= '0;
            r_wr_err   <= '0;
            r_wr_done  <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            r_wr_done  <= 1'b0;
            if (r_wr_state == WR_IDLE && wr_req_i) begin
                r_wr_addr <= wr_addr_i;
                r_wr_len  <= w_wr_len;
                r_wr_cnt  <= '0;
                r_wr_err  <= w_wr_x ? 2'b11 : 2'b00;
                r_wr_done <= w_wr_x;
            end
            if (w_w_hs) r_wr_cnt <= r_wr_cnt + 8'd1;
            if (r_wr_state == WR_B && axi_mgr_if.b_valid) begin
                r_wr_err  <= axi_mgr_if.b_resp;
                r_wr_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_rd_state <= RD_IDLE;
            r_rd_addr  <= '0;
            r_rd_len   <= '0;
            r_rd_cnt   <= '0;
            r_rd_err   <= '0;
            r_rd_done  <= 1'b0;
        end else begin
            r_rd_state <= w_rd_next;
            r_rd_done  <= 1'b0;
            if (r_rd_state == RD_IDLE && rd_req_i) begin
                r_rd_addr <= rd_addr_i;
                r_rd_len  <= w_rd_len;
                r_rd_cnt  <= '0;
                r_rd_err  <= w_rd_x ? 2'b11 : 2'b00;
                r_rd_done <= w_rd_x;
            end
            if (w_r_hs) begin
                r_rd_cnt <= r_rd_cnt + 9'd1;
                // a short or long burst overrides any slave error code
                if (axi_mgr_if.r_last) begin
                    r_rd_err  <= (r_rd_cnt != {1'b0, r_rd_len}) ? 2'b10 :
                                 (r_rd_err != 2'b00) ? r_rd_err : axi_mgr_if.r_resp;
                    r_rd_done <= 1'b1;
                end else if (r_rd_err == 2'b00) begin
                    r_rd_err <= axi_mgr_if.r_resp;
                end
            end
        end
    end

    assign axi_mgr_if.aw_id     = AXI_ID_WIDTH'(WR_ID);
    assign axi_mgr_if.aw_addr   = r_wr_addr;
    assign axi_mgr_if.aw_len    = r_wr_len;
    assign axi_mgr_if.aw_size   = 3'(SIZE);
    assign axi_mgr_if.aw_burst  = 2'b01;
    assign axi_mgr_if.aw_lock   = 1'b0;
    assign axi_mgr_if.aw_cache  = '0;
    assign axi_mgr_if.aw_prot   = '0;
    assign axi_mgr_if.aw_qos    = '0;
    assign axi_mgr_if.aw_region = '0;
    assign axi_mgr_if.aw_atop   = '0;
    assign axi_mgr_if.aw_user   = 1'b0;
    assign axi_mgr_if.aw_valid  = w_aw_valid;
    assign axi_mgr_if.w_data    = wr_fifo_data_i;
    assign axi_mgr_if.w_strb    = '1;
    assign axi_mgr_if.w_last    = w_w_last;
    assign axi_mgr_if.w_user    = 1'b0;
    assign axi_mgr_if.w_valid   = w_w_valid;
    assign axi_mgr_if.b_ready   = w_b_ready;
    assign axi_mgr_if.ar_id     = AXI_ID_WIDTH'(RD_ID);
    assign axi_mgr_if.ar_addr   = r_rd_addr;
    assign axi_mgr_if.ar_len    = r_rd_len;
    assign axi_mgr_if.ar_size   = 3'(SIZE);
    assign axi_mgr_if.ar_burst  = 2'b01;
    assign axi_mgr_if.ar_lock   = 1'b0;
    assign axi_mgr_if.ar_cache  = '0;
    assign axi_mgr_if.ar_prot   = '0;
    assign axi_mgr_if.ar_qos    = '0;
    assign axi_mgr_if.ar_region = '0;
    assign axi_mgr_if.ar_user   = 1'b0;
    assign axi_mgr_if.ar_valid  = w_ar_valid;
    assign axi_mgr_if.r_ready   = w_r_ready;

    assign wr_fifo_req_o  = w_w_hs;
    assign rd_fifo_gnt_o  = w_r_hs;
    assign rd_fifo_data_o = axi_mgr_if.r_data;
    assign wr_done_o      = r_wr_done;
    assign rd_done_o      = r_rd_done;
    assign wr_err_o       = r_wr_err;
    assign rd_err_o       = r_rd_err;
    assign busy_o         = rstn_i & ((r_wr_state != WR_IDLE) | (r_rd_state != RD_IDLE));
endmodule

// File: tb/tb_axi4_burst_mgr.sv
// tb_axi4_burst_mgr: directed bench for axi4_burst_mgr with a scoreboard of expected FIFO/bus beats.
module tb_axi4_burst_mgr;
    logic        clk;
    logic        rstn_i;
    logic        wr_req_i, rd_req_i;
    logic [31:0] wr_addr_i, rd_addr_i;
    logic [7:0]  wr_len_i, rd_len_i;
    logic        wr_fifo_gnt_i;
    logic [63:0] wr_fifo_data_i;
    logic        wr_fifo_req_o;
    logic        rd_fifo_req_i;
    logic        rd_fifo_gnt_o;
    logic [63:0] rd_fifo_data_o;
    logic        wr_done_o, rd_done_o;
    logic [1:0]  wr_err_o, rd_err_o;
    logic        busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] wq[$];
    logic [63:0] wexp[$];
    logic [63:0] rexp[$];

    axi4_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(9)) bus ();

    axi4_burst_mgr dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .wr_req_i      (wr_req_i),
        .wr_addr_i     (wr_addr_i),
        .wr_len_i      (wr_len_i),
        .rd_req_i      (rd_req_i),
        .rd_addr_i     (rd_addr_i),
        .rd_len_i      (rd_len_i),
        .wr_fifo_gnt_i (wr_fifo_gnt_i),
        .wr_fifo_data_i(wr_fifo_data_i),
        .wr_fifo_req_o (wr_fifo_req_o),
        .rd_fifo_req_i (rd_fifo_req_i),
        .rd_fifo_gnt_o (rd_fifo_gnt_o),
        .rd_fifo_data_o(rd_fifo_data_o),
        .wr_done_o     (wr_done_o),
        .rd_done_o     (rd_done_o),
        .wr_err_o      (wr_err_o),
        .rd_err_o      (rd_err_o),
        .busy_o        (busy_o),
        .axi_mgr_if    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fifo_drive();
        wr_fifo_gnt_i  = (wq.size() != 0);
        wr_fifo_data_i = (wq.size() != 0) ? wq[0] : 64'd0;
    endtask

    // Drives one write request and plays the slave; abort_at>0 returns right after that many W beats.
    task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input int nb,
                            input logic [1:0] bresp, input logic exp_busy, input int abort_at);
        int aw_hs = 0;
        int w_hs  = 0;
        logic aw_seen = 1'b0;
        logic b_pend  = 1'b0;
        logic done    = 1'b0;
        logic [7:0] exp_len = (len > 8'd15) ? 8'd15 : len;
        for (int i = 0; i < nb; i++) begin
            wq.push_back({addr, 32'(i)});
            wexp.push_back({addr, 32'(i)});
        end
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            wr_req_i = (cyc == 0);
            wr_addr_i = addr;
            wr_len_i = len;
            fifo_drive();
            bus.aw_ready = aw_seen;
            bus.w_ready = 1'b1;
            bus.b_valid = b_pend;
            bus.b_resp = bresp;
            #1;
            if (cyc == 1) chk("wr_err_clear", wr_err_o, 2'b00);
            if (bus.aw_valid) begin
                chk("aw_addr", bus.aw_addr, addr);
                chk("aw_len", bus.aw_len, exp_len);
                chk("aw_burst_size", {bus.aw_burst, bus.aw_size}, 5'b01_011);
                if (bus.aw_ready) aw_hs++;
                aw_seen = 1'b1;
            end else aw_seen = 1'b0;
            if (bus.w_valid && aw_hs == 0) chk("w_early", bus.w_valid, 1'b0);
            if (bus.w_valid && bus.w_ready) begin
                chk("w_pop", wr_fifo_req_o, 1'b1);
                chk("w_data", bus.w_data, wexp.pop_front());
                chk("w_last", bus.w_last, w_hs == nb - 1);
                void'(wq.pop_front());
                w_hs++;
                if (w_hs == nb) b_pend = 1'b1;
                if (abort_at > 0 && w_hs == abort_at) return;
            end
            if (bus.b_valid && bus.b_ready) b_pend = 1'b0;
            if (wr_done_o) begin
                chk("wr_err", wr_err_o, bresp);
                chk("wr_busy_at_done", busy_o, exp_busy);
                chk("wr_beats", w_hs, nb);
                done = 1'b1;
            end
        end
        if (!done) chk("wr_timeout", done, 1'b1);
        bus.aw_ready = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("wr_done_pulse", wr_done_o, 1'b0);
    endtask

    // Plays the read slave sending nsend beats; beat bad_at gets bad_resp, the one after gets SLVERR.
    task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input int nsend,
                            input logic toggle, input int bad_at, input logic [1:0] bad_resp,
                            input logic [1:0] exp_err, input logic exp_busy);
        int ar_hs = 0;
        int beat  = 0;
        logic ar_seen = 1'b0;
        logic done    = 1'b0;
        for (int i = 0; i < nsend; i++) rexp.push_back({addr, 32'(i)});
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            rd_req_i = (cyc == 0);
            rd_addr_i = addr;
            rd_len_i = len;
            rd_fifo_req_i = toggle ? cyc[0] : 1'b1;
            bus.ar_ready = ar_seen;
            bus.r_valid = (ar_hs != 0) && (beat < nsend);
            bus.r_data = {addr, 32'(beat)};
            bus.r_last = (beat == nsend - 1);
            bus.r_resp = (beat == bad_at) ? bad_resp : (beat == bad_at + 1) ? 2'b10 : 2'b00;
            #1;
            if (cyc == 1) chk("rd_err_clear", rd_err_o, 2'b00);
            if (bus.ar_valid) begin
                chk("ar_addr", bus.ar_addr, addr);
                chk("ar_len", bus.ar_len, len);
                chk("ar_burst_size", {bus.ar_burst, bus.ar_size}, 5'b01_011);
                if (bus.ar_ready) ar_hs++;
                ar_seen = 1'b1;
            end else ar_seen = 1'b0;
            if (bus.r_valid && bus.r_ready) begin
                chk("rd_push", rd_fifo_gnt_o, 1'b1);
                chk("rd_data", rd_fifo_data_o, rexp.pop_front());
                beat++;
            end else if (rd_fifo_gnt_o) chk("rd_push_spurious", rd_fifo_gnt_o, 1'b0);
            if (rd_done_o) begin
                chk("rd_err", rd_err_o, exp_err);
                chk("rd_busy_at_done", busy_o, exp_busy);
                chk("rd_beats", beat, nsend);
                done = 1'b1;
            end
        end
        if (!done) chk("rd_timeout", done, 1'b1);
        bus.ar_ready = 1'b0;
        bus.r_valid = 1'b0;
        rd_fifo_req_i = 1'b0;
    endtask

    initial begin
        rstn_i = 1'b0;
        wr_req_i = 1'b0; rd_req_i = 1'b0;
        wr_addr_i = '0; rd_addr_i = '0; wr_len_i = '0; rd_len_i = '0;
        wr_fifo_gnt_i = 1'b0; wr_fifo_data_i = '0; rd_fifo_req_i = 1'b0;
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = 2'b00;
        bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = 2'b00; bus.r_last = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_valids", {bus.aw_valid, bus.w_valid, bus.ar_valid}, 3'b000);
        chk("rst_readies", {bus.b_ready, bus.r_ready}, 2'b00);
        chk("rst_fifo", {wr_fifo_req_o, rd_fifo_gnt_o}, 2'b00);
        chk("rst_done", {wr_done_o, rd_done_o}, 2'b00);
        chk("rst_err", {wr_err_o, rd_err_o}, 4'b0000);
        @(negedge clk);
        rstn_i = 1'b1;

        wr_burst(32'h5000, 8'd3, 4, 2'b00, 1'b0, 0);
        wr_burst(32'h7000, 8'd0, 1, 2'b10, 1'b0, 0);
        wr_burst(32'h7100, 8'd1, 2, 2'b00, 1'b0, 0);

        rd_burst(32'h6000, 8'd7, 8, 1'b1, 100, 2'b00, 2'b00, 1'b0);
        rd_burst(32'h6100, 8'd3, 4, 1'b0, 1, 2'b11, 2'b11, 1'b0);
        rd_burst(32'h6200, 8'd3, 3, 1'b0, 100, 2'b00, 2'b10, 1'b0);

        fork
            wr_burst(32'h8000, 8'd3, 4, 2'b00, 1'b1, 0);
            rd_burst(32'h9000, 8'd7, 8, 1'b1, 100, 2'b00, 2'b00, 1'b0);
        join
        #1;
        chk("busy_after_both", busy_o, 1'b0);

        wr_burst(32'hA000, 8'd40, 16, 2'b00, 1'b0, 0);

`ifdef AXI4_BURST_MGR_4K_CHECK_EN
        @(negedge clk);
        wr_req_i = 1'b1; wr_addr_i = 32'h0FF8; wr_len_i = 8'd1;
        @(negedge clk);
        wr_req_i = 1'b0;
        #1;
        chk("x4k_done", wr_done_o, 1'b1);
        chk("x4k_err", wr_err_o, 2'b11);
        chk("x4k_no_aw", bus.aw_valid, 1'b0);
        chk("x4k_idle", busy_o, 1'b0);
        @(negedge clk);
        #1;
        chk("x4k_no_aw_later", bus.aw_valid, 1'b0);
`else
        wr_burst(32'h0FF8, 8'd1, 2, 2'b00, 1'b0, 0);
`endif

        wr_burst(32'hB000, 8'd3, 4, 2'b00, 1'b0, 2);
        @(negedge clk);
        rstn_i = 1'b0;
        #1;
        chk("rst_mid_w_valid", {bus.aw_valid, bus.w_valid, wr_fifo_req_o}, 3'b000);
        chk("rst_mid_busy", busy_o, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_mid_after_edge", {bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid}, 4'b0000);
        chk("rst_mid_err", {wr_err_o, wr_done_o}, 3'b000);
        wq.delete();
        wexp.delete();
        fifo_drive();
        rstn_i = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_idle", {busy_o, bus.w_valid}, 2'b00);
        wr_burst(32'hC000, 8'd3, 4, 2'b00, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axi4_burst_mgr.md
AXI4_BURST_MGR -- requirements
Module: axi4_burst_mgr

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, data width; AXI size = log2(AXI_DATA_WIDTH/8).
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 9, ID width.
REQ-004 SHALL have parameter WR_ID, default 0, constant aw_id.
REQ-005 SHALL have parameter RD_ID, default 0, constant ar_id.
REQ-006 SHALL have parameter MAX_BURST_LEN, default 16, maximum beats per burst (1..256).
REQ-007 SHALL have ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rstn_i  in  1  reset; synchronous, active-low.
- wr_req_i / rd_req_i  in  1  single-cycle start pulse for a write / read burst.
- wr_addr_i / rd_addr_i  in  AXI_ADDR_WIDTH  burst start address.
- wr_len_i / rd_len_i  in  8  beats-1.
- wr_fifo_gnt_i  in  1  write-data FIFO non-empty.
- wr_fifo_data_i  in  AXI_DATA_WIDTH  write-data FIFO head.
- wr_fifo_req_o  out  1  write-data FIFO pop.
- rd_fifo_req_i  in  1  read-data FIFO not full.
- rd_fifo_gnt_o  out  1  read-data FIFO push.
- rd_fifo_data_o  out  AXI_DATA_WIDTH  read data to FIFO.
- wr_done_o / rd_done_o  out  1  one-cycle completion pulse.
- wr_err_o / rd_err_o  out  2  response code of last burst.
- busy_o  out  1  either channel not IDLE.
- axi_mgr_if  axi4_bus_if  manager modport.

Function
REQ-008 SHALL run independent write FSM (IDLE->AW->W->B->IDLE) and read FSM (IDLE->AR->R->IDLE); both may be active at once.
REQ-009 SHALL accept a request only in IDLE; latch addr/len that cycle; requests in any other state ignored, no queuing.
REQ-010 SHALL clamp len to MAX_BURST_LEN-1 when larger.
REQ-011 SHALL drive burst=INCR, size per REQ-002, lock/cache/prot/qos/region/atop/user=0, ids per REQ-004/005.
REQ-012 SHALL hold aw_valid/ar_valid high from the cycle after acceptance until ready sampled high; address/len stable throughout.
REQ-013 SHALL in W drive w_valid=wr_fifo_gnt_i, w_data=wr_fifo_data_i, w_strb all ones, wr_fifo_req_o=w_valid&w_ready (combinational, zero-latency pop).
REQ-014 SHALL assert w_last exactly on beat count == latched len; W->B on that beat's handshake.
REQ-015 SHALL in B hold b_ready=1; on handshake latch b_resp into wr_err_o, pulse wr_done_o, go IDLE.
REQ-016 SHALL in R drive r_ready=rd_fifo_req_i, rd_fifo_data_o=r_data, rd_fifo_gnt_o=r_valid&r_ready.
REQ-017 SHALL latch the first non-OKAY r_resp of a burst into rd_err_o, else 2'b00; pulse rd_done_o and go IDLE on r_last handshake.
REQ-018 SHALL set rd_err_o=2'b10 if r_last beat count differs from latched len+1.
REQ-019 SHALL clear wr_err_o/rd_err_o on acceptance of the next request of that channel.
REQ-020 SHALL permit w_valid before aw handshake only after AW state exits (no early write data).

Reset
REQ-021 SHALL, on rstn_i low at a clock edge, force both FSMs to IDLE regardless of state, counters to 0, wr_err_o/rd_err_o=0, done pulses 0.
REQ-022 SHALL hold all valid, ready, FIFO req/gnt and busy_o at 0 during and immediately after reset; an interrupted burst is abandoned, not resumed.

Configuration
REQ-023 SHALL, with AXI4_BURST_MGR_4K_CHECK_EN defined, reject a request whose burst crosses a 4 KiB boundary: no AXI transaction, err output=2'b11, done pulse the next cycle, FSM stays IDLE.
REQ-024 SHALL, without AXI4_BURST_MGR_4K_CHECK_EN, issue every request unchecked.

Verification
REQ-025 Write: addr 0x5000, len 3, FIFO holds 0..3, slave OKAY -> 4 W beats data 0..3, w_last on beat 4, wr_done_o pulse, wr_err_o=00.
REQ-026 Read: addr 0x6000, len 7, rd_fifo_req_i toggling every cycle -> 8 pushes in order, no beat lost, rd_done_o pulse.
REQ-027 Concurrent wr_req_i and rd_req_i same cycle -> both bursts complete, busy_o low only after both done.
REQ-028 len 40 with MAX_BURST_LEN=16 -> aw_len=15, 16 beats.
REQ-029 Macro defined, addr 0x0FF8, len 1 -> no aw_valid, wr_err_o=11; macro undefined -> burst issued.
REQ-030 rstn_i low mid-W (beat 2 of 4) -> next edge all valids 0, FSM IDLE, new request then completes normally.
